grid_tick_controller: RTL and testbench
=======================================

# grid_tick_controller

- Global tick sequencer for a grid of NUM_CORES cores.
- Watches per-core completion and router quiescence, then declares the time step finished.
- Issues a one-cycle tick together with a per-core counter clear.
- Counts ticks against a programmed run length and flags cores that fail to settle within a timeout.
- Sits above the core array as the single source of tick and core_clr for every core.

## Interface
Parameters:
- NUM_CORES, 4, number of cores supervised
- SETTLE_CYCLES, 8, consecutive quiet cycles required before a tick (≥1)
- TIMEOUT_CYCLES, 4096, max cycles spent waiting per tick before error (> SETTLE_CYCLES)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  pulse; begins a run from IDLE or ERR
- stop  in  1  pulse; requests graceful end after the current tick
- num_ticks_cfg  in  16  run length in ticks, sampled on accepted start; 0 = free-run until stop
- core_done  in  NUM_CORES  per-core "all received packets processed"
- core_idle  in  NUM_CORES  per-core axon FIFO empty and controller idle
- router_idle  in  NUM_CORES  per-core all router buffers empty
- tick  out  1  one-cycle time-step pulse
- core_clr  out  1  one-cycle clear of per-core packet counters; coincident with tick
- tick_count  out  16  ticks issued in current run
- busy  out  1  high in RUN, SETTLE, TICK
- done  out  1  one-cycle pulse at run end
- timeout_err  out  1  sticky error flag
- stuck_mask  out  NUM_CORES  cores not quiet at timeout

## Operation
- Quiet condition, all_quiet = &(core_done | core_idle) & &router_idle.
- States: IDLE, RUN, SETTLE, TICK, DONE, ERR. All outputs are decodes of registered state/counters; no combinational input-to-output path.
- IDLE:
  - On start, latch target = num_ticks_cfg, clear tick_count, stop_pending, timeout_cnt, then go to RUN.
  - stop is ignored; start and stop in the same cycle → start accepted, stop dropped.
- RUN:
  - timeout_cnt increments each cycle.
  - If all_quiet, go to SETTLE with settle_cnt = 0.
- SETTLE:
  - timeout_cnt increments each cycle.
  - If !all_quiet, return to RUN; settle_cnt is cleared and timeout_cnt is kept.
  - If all_quiet and settle_cnt == SETTLE_CYCLES-1, go to TICK; otherwise settle_cnt increments.
- Timeout:
  - In RUN/SETTLE, timeout_cnt == TIMEOUT_CYCLES-1 sends the block to ERR.
  - stuck_mask latches ~(core_done | core_idle) | ~router_idle on that cycle.
  - If the SETTLE→TICK transition occurs in the same cycle, TICK wins.
- TICK:
  - tick = core_clr = 1; tick_count increments, 16-bit wrap (free-run only).
  - Next state is DONE if (target != 0 and tick_count+1 == target) or stop_pending; otherwise RUN with timeout_cnt cleared.
- stop pulse in RUN/SETTLE/TICK sets stop_pending. The in-progress tick still completes; no tick is aborted.
- DONE: done = 1 for one cycle, then IDLE. tick_count holds its final value until the next start.
- ERR:
  - timeout_err = 1 and busy = 0; tick is never issued.
  - start clears timeout_err and stuck_mask and begins a fresh run as from IDLE. stop is ignored.

## Timing
- Reset: state IDLE. tick, core_clr, done, busy, timeout_err = 0; tick_count = 0; stuck_mask = 0. All internal counters 0; stop_pending = 0.
- start sampled at cycle S → busy high from S+1.
- First all_quiet cycle Q in RUN, held continuously:
  - SETTLE during Q+1 .. Q+SETTLE_CYCLES.
  - tick high at Q+SETTLE_CYCLES+1.
  - Next RUN at Q+SETTLE_CYCLES+2.
- Minimum tick period with cores always quiet: SETTLE_CYCLES+2 cycles.
- Final tick at cycle T → done at T+1, IDLE at T+2.
- tick_count updates the cycle after tick (visible at T+1).
- Timeout fires on the TIMEOUT_CYCLES-th cycle after entering RUN → timeout_err high the following cycle.
- rst mid-run overrides everything next edge: no tick, no done pulse.

## Test plan
- NUM_CORES=4, SETTLE_CYCLES=8, num_ticks_cfg=3, all inputs quiet, start at cycle 10 → tick at cycles 20, 30, 40; done at 41; tick_count=3; busy low from 42.
- Quiet, then core_idle[2]/core_done[2] drop at SETTLE cycle 5 for 2 cycles → no tick; settle restarts; tick 9 cycles after quiet resumes; core_clr coincident with tick.
- num_ticks_cfg=0, stop pulsed mid-SETTLE of the 5th tick → 5th tick still issued, done next cycle, tick_count=5.
- core_done[1]=core_idle[1]=0 forever, TIMEOUT_CYCLES=64 → no tick; timeout_err=1; stuck_mask=4'b0010. A later start clears both.
- Settle completion coincides with timeout_cnt=TIMEOUT_CYCLES-1 → tick issued, no error. Also assert rst during SETTLE → all outputs return to reset values next cycle, no tick.
- Free-run, tick_count preloaded near 16'hFFFF via long run → wraps to 0 with no done pulse.

Source files
------------

// File: rtl/grid_tick_controller.sv
// grid_tick_controller
//   Global time-step sequencer for a grid of NUM_CORES cores. It waits until
//   every core is done or idle and every router is empty, requires that
//   condition to hold for SETTLE_CYCLES consecutive cycles, and then issues a
//   one-cycle tick with a coincident core_clr. Ticks are counted against a
//   run length latched at start. Cores that never settle trip a timeout.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   start             pulse; begins a run from IDLE or ERR
//   stop              pulse; graceful end after the tick in progress
//   num_ticks_cfg     run length in ticks (0 = free-run until stop)
//   core_done         per-core: all received packets processed
//   core_idle         per-core: axon FIFO empty and controller idle
//   router_idle       per-core: all router buffers empty
//   tick, core_clr    one-cycle time-step pulse and counter clear
//   tick_count        ticks issued in the current run
//   busy              high while running, settling or ticking
//   done              one-cycle pulse at run end
//   timeout_err       high while in the error state
//   stuck_mask        cores that were not quiet when the timeout fired
//
// Every output is a decode of registered state, so there is no
// combinational path from any input to any output.
module grid_tick_controller #(
  parameter int NUM_CORES      = 4,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [15:0]          num_ticks_cfg,
  input  logic [NUM_CORES-1:0] core_done,
  input  logic [NUM_CORES-1:0] core_idle,
  input  logic [NUM_CORES-1:0] router_idle,
  output logic                 tick,
  output logic                 core_clr,
  output logic [15:0]          tick_count,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic [NUM_CORES-1:0] stuck_mask
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SETTLE,
    S_TICK,
    S_DONE,
    S_ERR
  } state_t;

  state_t               state, state_nx;
  logic [15:0]          target, target_nx;
  logic [15:0]          tick_count_nx, tick_count_inc;
  logic                 stop_pending, stop_pending_nx;
  logic [TW-1:0]        timeout_cnt, timeout_cnt_nx;
  logic [SW-1:0]        settle_cnt, settle_cnt_nx;
  logic [NUM_CORES-1:0] stuck_mask_nx;
  logic [NUM_CORES-1:0] not_quiet;
  logic                 all_quiet;
  logic                 timeout_hit;
  logic                 settle_hit;
  logic                 run_last;

  // A core is quiet when it is done or idle and its router is empty.
  assign not_quiet      = ~(core_done | core_idle) | ~router_idle;
  assign all_quiet      = ~|not_quiet;
  assign timeout_hit    = (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign settle_hit     = (settle_cnt == SW'(SETTLE_CYCLES - 1));
  assign tick_count_inc = tick_count + 16'd1;
  assign run_last       = (target != 16'd0) && (tick_count_inc == target);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      target       <= '0;
      tick_count   <= '0;
      stop_pending <= 1'b0;
      timeout_cnt  <= '0;
      settle_cnt   <= '0;
      stuck_mask   <= '0;
    end else begin
      state        <= state_nx;
      target       <= target_nx;
      tick_count   <= tick_count_nx;
      stop_pending <= stop_pending_nx;
      timeout_cnt  <= timeout_cnt_nx;
      settle_cnt   <= settle_cnt_nx;
      stuck_mask   <= stuck_mask_nx;
    end
  end

  always_comb begin
    state_nx        = state;
    target_nx       = target;
    tick_count_nx   = tick_count;
    stop_pending_nx = stop_pending;
    timeout_cnt_nx  = timeout_cnt;
    settle_cnt_nx   = settle_cnt;
    stuck_mask_nx   = stuck_mask;

    unique case (state)
      S_IDLE, S_ERR: begin
        // start wins over a simultaneous stop, which is simply dropped.
        if (start) begin
          state_nx        = S_RUN;
          target_nx       = num_ticks_cfg;
          tick_count_nx   = '0;
          stop_pending_nx = 1'b0;
          timeout_cnt_nx  = '0;
          settle_cnt_nx   = '0;
          stuck_mask_nx   = '0;
        end
      end

      S_RUN: begin
        if (stop) stop_pending_nx = 1'b1;
        timeout_cnt_nx = timeout_cnt + TW'(1);
        if (timeout_hit) begin
          state_nx      = S_ERR;
          stuck_mask_nx = not_quiet;
        end else if (all_quiet) begin
          state_nx      = S_SETTLE;
          settle_cnt_nx = '0;
        end
      end

      S_SETTLE: begin
        if (stop) stop_pending_nx = 1'b1;
        timeout_cnt_nx = timeout_cnt + TW'(1);
        // Completing the settle window takes priority over a timeout that
        // lands on the same cycle.
        if (all_quiet && settle_hit) begin
          state_nx = S_TICK;
        end else if (timeout_hit) begin
          state_nx      = S_ERR;
          stuck_mask_nx = not_quiet;
        end else if (!all_quiet) begin
          state_nx      = S_RUN;
          settle_cnt_nx = '0;
        end else begin
          settle_cnt_nx = settle_cnt + SW'(1);
        end
      end

      S_TICK: begin
        if (stop) stop_pending_nx = 1'b1;
        tick_count_nx = tick_count_inc;
        if (run_last || stop_pending) begin
          state_nx = S_DONE;
        end else begin
          state_nx       = S_RUN;
          timeout_cnt_nx = '0;
        end
      end

      S_DONE: begin
        state_nx = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  assign tick        = (state == S_TICK);
  assign core_clr    = (state == S_TICK);
  assign done        = (state == S_DONE);
  assign busy        = (state == S_RUN) || (state == S_SETTLE) || (state == S_TICK);
  assign timeout_err = (state == S_ERR);

endmodule

// File: tb/tb_grid_tick_controller.sv
// tb_grid_tick_controller
//   Directed scenarios plus randomized stimulus for grid_tick_controller.
//   A behavioural model (wait for SETTLE+1 consecutive quiet cycles, bounded
//   by a per-tick wait budget) predicts every output each cycle; a few
//   directed scenarios also pin exact cycle numbers with literal values.
module tb_grid_tick_controller;

  localparam int NC     = 4;
  localparam int SETTLE = 8;
  localparam int TMO    = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic [15:0]   num_ticks_cfg;
  logic [NC-1:0] core_done;
  logic [NC-1:0] core_idle;
  logic [NC-1:0] router_idle;
  logic          tick;
  logic          core_clr;
  logic [15:0]   tick_count;
  logic          busy;
  logic          done;
  logic          timeout_err;
  logic [NC-1:0] stuck_mask;

  grid_tick_controller #(
    .NUM_CORES      (NC),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stop          (stop),
    .num_ticks_cfg (num_ticks_cfg),
    .core_done     (core_done),
    .core_idle     (core_idle),
    .router_idle   (router_idle),
    .tick          (tick),
    .core_clr      (core_clr),
    .tick_count    (tick_count),
    .busy          (busy),
    .done          (done),
    .timeout_err   (timeout_err),
    .stuck_mask    (stuck_mask)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {P_IDLE, P_WAIT, P_TICK, P_DONE, P_ERR} phase_t;
  phase_t        ph = P_IDLE;
  int unsigned   streak = 0;   // consecutive quiet cycles seen while waiting
  int unsigned   waited = 0;   // cycles spent waiting for the current tick
  logic [15:0]   m_target = '0;
  logic [15:0]   m_count = '0;
  bit            m_stop = 1'b0;
  logic [NC-1:0] m_stuck = '0;

  always @(posedge clk) begin
    logic [NC-1:0] nq;
    nq = ~(core_done | core_idle) | ~router_idle;
    if (rst) begin
      ph = P_IDLE; streak = 0; waited = 0;
      m_target = '0; m_count = '0; m_stop = 1'b0; m_stuck = '0;
    end else begin
      case (ph)
        P_IDLE, P_ERR: begin
          if (start) begin
            ph = P_WAIT; streak = 0; waited = 0;
            m_target = num_ticks_cfg; m_count = '0; m_stop = 1'b0; m_stuck = '0;
          end
        end
        P_WAIT: begin
          if (stop) m_stop = 1'b1;
          waited++;
          streak = (nq == '0) ? streak + 1 : 0;
          if (streak == SETTLE + 1) ph = P_TICK;
          else if (waited == TMO) begin
            ph = P_ERR;
            m_stuck = nq;
          end
        end
        P_TICK: begin
          if ((m_target != 0 && int'(m_count) + 1 == int'(m_target)) || m_stop) ph = P_DONE;
          else begin
            ph = P_WAIT; streak = 0; waited = 0;
          end
          m_count = m_count + 16'd1;
          if (stop) m_stop = 1'b1;
        end
        P_DONE: ph = P_IDLE;
        default: ph = P_IDLE;
      endcase
    end
  end

  // ---------------- per-cycle compare + event log ----------------
  int tick_q[$];
  int done_cyc = -1;
  int clr_cyc  = -1;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      chk("tick",        32'(tick),        32'(ph == P_TICK));
      chk("core_clr",    32'(core_clr),    32'(ph == P_TICK));
      chk("done",        32'(done),        32'(ph == P_DONE));
      chk("busy",        32'(busy),        32'(ph == P_WAIT || ph == P_TICK));
      chk("timeout_err", 32'(timeout_err), 32'(ph == P_ERR));
      chk("tick_count",  32'(tick_count),  32'(m_count));
      chk("stuck_mask",  32'(stuck_mask),  32'(m_stuck));
      if (tick) tick_q.push_back(cyc);
      if (core_clr) clr_cyc = cyc;
      if (done) done_cyc = cyc;
    end
  end

  function automatic int tick_at(int i);
    if (i < tick_q.size()) return tick_q[i];
    return -1;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_quiet();
    core_done = '1; core_idle = '1; router_idle = '1;
  endtask

  task automatic clear_log();
    tick_q.delete();
    done_cyc = -1;
    clr_cyc  = -1;
  endtask

  task automatic rand_inputs(input int mode, input int sc);
    logic [NC-1:0] d;
    bit quiet;
    quiet = (mode == 1) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 9) != 0);
    if (quiet) begin
      d = NC'($urandom);
      core_done = d;
      core_idle = ~d | NC'($urandom);
      router_idle = '1;
    end else begin
      core_done = NC'($urandom);
      core_idle = NC'($urandom);
      router_idle = NC'($urandom) | NC'($urandom);
    end
    if (mode == 2) begin
      core_done[sc] = 1'b0;
      core_idle[sc] = 1'b0;
    end
  endtask

  int s;
  int mode;
  int sc;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; num_ticks_cfg = '0;
    core_done = '0; core_idle = '0; router_idle = '0;
    cycles(3);
    chk("rst_tick",  32'(tick), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_count", 32'(tick_count), 0);
    chk("rst_err",   32'(timeout_err), 0);
    chk("rst_stuck", 32'(stuck_mask), 0);
    rst = 1'b0;
    set_quiet();
    cycles(2);

    // Three-tick run with everything quiet: ticks at +10,+20,+30, done +31.
    clear_log();
    num_ticks_cfg = 16'd3;
    s = cyc; start = 1'b1; cycles(1); start = 1'b0;
    cycles(45);
    chk("t1_ntick", 32'(tick_q.size()), 3);
    chk("t1_tick0", 32'(tick_at(0) - s), 10);
    chk("t1_tick1", 32'(tick_at(1) - s), 20);
    chk("t1_tick2", 32'(tick_at(2) - s), 30);
    chk("t1_done",  32'(done_cyc - s), 31);
    chk("t1_count", 32'(tick_count), 3);
    chk("t1_busy",  32'(busy), 0);

    // Core 2 drops out for two settle cycles; the window restarts.
    clear_log();
    num_ticks_cfg = 16'd1;
    s = cyc; start = 1'b1; cycles(1); start = 1'b0;
    cycles(5);
    core_done[2] = 1'b0; core_idle[2] = 1'b0;
    cycles(2);
    set_quiet();
    cycles(12);
    chk("t2_ntick", 32'(tick_q.size()), 1);
    chk("t2_tick",  32'(tick_at(0) - s), 17);
    chk("t2_clr",   32'(clr_cyc - s), 17);
    chk("t2_done",  32'(done_cyc - s), 18);

    // Free-run, stop mid-settle of the fifth tick.
    clear_log();
    num_ticks_cfg = 16'd0;
    s = cyc; start = 1'b1; cycles(1); start = 1'b0;
    cycles(44);
    stop = 1'b1; cycles(1); stop = 1'b0;
    cycles(10);
    chk("t3_ntick", 32'(tick_q.size()), 5);
    chk("t3_tick4", 32'(tick_at(4) - s), 50);
    chk("t3_done",  32'(done_cyc - s), 51);
    chk("t3_count", 32'(tick_count), 5);

    // Core 1 never settles: timeout, then a fresh start clears the error.
    clear_log();
    core_done[1] = 1'b0; core_idle[1] = 1'b0;
    s = cyc; start = 1'b1; cycles(1); start = 1'b0;
    cycles(70);
    chk("t4_ntick", 32'(tick_q.size()), 0);
    chk("t4_err",   32'(timeout_err), 1);
    chk("t4_stuck", 32'(stuck_mask), 32'h2);
    chk("t4_busy",  32'(busy), 0);
    set_quiet();
    num_ticks_cfg = 16'd1;
    start = 1'b1; cycles(1); start = 1'b0;
    chk("t4_clr_err",   32'(timeout_err), 0);
    chk("t4_clr_stuck", 32'(stuck_mask), 0);
    chk("t4_rebusy",    32'(busy), 1);
    cycles(15);

    // Settle completes exactly on the last allowed wait cycle: tick wins.
    clear_log();
    num_ticks_cfg = 16'd1;
    core_done[0] = 1'b0; core_idle[0] = 1'b0;
    s = cyc; start = 1'b1; cycles(1); start = 1'b0;
    cycles(55);
    set_quiet();
    cycles(14);
    chk("t5_ntick", 32'(tick_q.size()), 1);
    chk("t5_tick",  32'(tick_at(0) - s), 65);
    chk("t5_done",  32'(done_cyc - s), 66);
    chk("t5_err",   32'(timeout_err), 0);

    // Reset asserted mid-settle.
    clear_log();
    num_ticks_cfg = 16'd0;
    start = 1'b1; cycles(1); start = 1'b0;
    cycles(3);
    rst = 1'b1; cycles(1); rst = 1'b0;
    chk("t6_busy",  32'(busy), 0);
    chk("t6_tick",  32'(tick), 0);
    chk("t6_count", 32'(tick_count), 0);
    cycles(12);
    chk("t6_ntick", 32'(tick_q.size()), 0);
    chk("t6_done",  32'(done_cyc), 32'hFFFF_FFFF);

    // Randomized traffic checked every cycle by the model.
    mode = 0; sc = 0;
    for (int i = 0; i < 5000; i++) begin
      if (i % 60 == 0) begin
        mode = $urandom_range(0, 2);
        sc   = $urandom_range(0, NC - 1);
      end
      rand_inputs(mode, sc);
      start = ($urandom_range(0, 99) < 3);
      stop  = ($urandom_range(0, 99) < 2);
      rst   = ($urandom_range(0, 999) < 2);
      num_ticks_cfg = 16'($urandom_range(0, 5));
      cycles(1);
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
